id_ex_pipe_reg: RTL and testbench

//   Parametrised ID->EX pipeline register with valid/ready handshake and a
//   2-entry skid buffer, so a stalled EX stage never loses an issued instruction.

---
 rtl/id_ex_pipe_reg_if.sv | 18 +
 rtl/id_ex_pipe_reg.sv | 121 ++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/id_ex_pipe_reg_if.sv
// Valid/ready stream carrying one ID->EX instruction payload.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface id_ex_pipe_reg_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int OP_W    = 8,
    parameter int NUM_SRC = 2
);
    logic                      valid;
    logic                      ready;
    logic [OP_W-1:0]           op;
    logic [NUM_SRC*DATA_W-1:0] src;
    logic [ADDR_W-1:0]         waddr;
    logic                      wen;

    modport master (output valid, op, src, waddr, wen, input ready);
    modport slave  (input valid, op, src, waddr, wen, output ready);
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with a 2-entry skid buffer (MAIN drives EX, SKID holds the overflow).
// id_ready is decoded from the state register only, so there is no combinational ex_ready -> id_ready path.
module id_ex_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int OP_W    = 8,
    parameter int NUM_SRC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    id_ex_pipe_reg_if.slave     id,
    id_ex_pipe_reg_if.master    ex
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [OP_W-1:0]           main_op_q, main_op_d, skid_op_q, skid_op_d;
    logic [NUM_SRC*DATA_W-1:0] main_src_q, main_src_d, skid_src_q, skid_src_d;
    logic [ADDR_W-1:0]         main_waddr_q, main_waddr_d, skid_waddr_q, skid_waddr_d;
    logic                      main_wen_q, main_wen_d, skid_wen_q, skid_wen_d;
    logic                      in_hs, out_hs;

    assign id.ready = (state_q != FULL);
    assign ex.valid = (state_q != EMPTY);
    assign ex.op    = main_op_q;
    assign ex.src   = main_src_q;
    assign ex.waddr = main_waddr_q;
    assign ex.wen   = main_wen_q & ex.valid;

    assign in_hs  = id.valid & id.ready;
    assign out_hs = ex.valid & ex.ready;

    always_comb begin
        state_d      = state_q;
        main_op_d    = main_op_q;
        main_src_d   = main_src_q;
        main_waddr_d = main_waddr_q;
        main_wen_d   = main_wen_q;
        skid_op_d    = skid_op_q;
        skid_src_d   = skid_src_q;
        skid_waddr_d = skid_waddr_q;
        skid_wen_d   = skid_wen_q;
        if (flush) begin
            state_d      = EMPTY;
            main_op_d    = '0;
            main_src_d   = '0;
            main_waddr_d = '0;
            main_wen_d   = 1'b0;
            skid_op_d    = '0;
            skid_src_d   = '0;
            skid_waddr_d = '0;
            skid_wen_d   = 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_hs) begin
                        main_op_d    = id.op;
                        main_src_d   = id.src;
                        main_waddr_d = id.waddr;
                        main_wen_d   = id.wen;
                        state_d      = BUSY;
                    end
                end
                BUSY: begin
                    if (in_hs && out_hs) begin
                        main_op_d    = id.op;
                        main_src_d   = id.src;
                        main_waddr_d = id.waddr;
                        main_wen_d   = id.wen;
                    end else if (in_hs) begin
                        // EX stalled: park the newcomer behind the head entry
                        skid_op_d    = id.op;
                        skid_src_d   = id.src;
                        skid_waddr_d = id.waddr;
                        skid_wen_d   = id.wen;
                        state_d      = FULL;
                    end else if (out_hs) begin
                        state_d      = EMPTY;
                    end
                end
                FULL: begin
                    if (out_hs) begin
                        main_op_d    = skid_op_q;
                        main_src_d   = skid_src_q;
                        main_waddr_d = skid_waddr_q;
                        main_wen_d   = skid_wen_q;
                        state_d      = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= EMPTY;
            main_op_q    <= '0;
            main_src_q   <= '0;
            main_waddr_q <= '0;
            main_wen_q   <= 1'b0;
            skid_op_q    <= '0;
            skid_src_q   <= '0;
            skid_waddr_q <= '0;
            skid_wen_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            main_op_q    <= main_op_d;
            main_src_q   <= main_src_d;
            main_waddr_q <= main_waddr_d;
            main_wen_q   <= main_wen_d;
            skid_op_q    <= skid_op_d;
            skid_src_q   <= skid_src_d;
            skid_waddr_q <= skid_waddr_d;
            skid_wen_q   <= skid_wen_d;
        end
    end
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_id_ex_pipe_reg;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   tests = 0;
    int   fails = 0;

    id_ex_pipe_reg_if #(.DATA_W(32), .ADDR_W(5), .OP_W(8), .NUM_SRC(2)) id_if ();
    id_ex_pipe_reg_if #(.DATA_W(32), .ADDR_W(5), .OP_W(8), .NUM_SRC(2)) ex_if ();

    id_ex_pipe_reg #(.DATA_W(32), .ADDR_W(5), .OP_W(8), .NUM_SRC(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .id    (id_if),
        .ex    (ex_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] op, input logic [63:0] src, input logic [4:0] waddr, input logic wen);
        id_if.valid = 1'b1;
        id_if.op    = op;
        id_if.src   = src;
        id_if.waddr = waddr;
        id_if.wen   = wen;
    endtask

    initial begin
        // reset with random inputs applied
        rst          = 1'b0;
        flush        = 1'b0;
        id_if.valid  = 1'b1;
        id_if.op     = 8'($urandom);
        id_if.src    = {$urandom, $urandom};
        id_if.waddr  = 5'($urandom);
        id_if.wen    = 1'b1;
        ex_if.ready  = 1'($urandom);
        @(posedge clk); #2;
        chk("rst_ex_valid", 64'(ex_if.valid), 64'd0);
        chk("rst_ex_wen",   64'(ex_if.wen),   64'd0);
        chk("rst_ex_src",   ex_if.src,        64'd0);
        chk("rst_ex_waddr", 64'(ex_if.waddr), 64'd0);
        chk("rst_ex_op",    64'(ex_if.op),    64'd0);
        @(negedge clk);
        id_if.valid = 1'b0;
        ex_if.ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rel_id_ready", 64'(id_if.ready), 64'd1);
        @(negedge clk);
        chk("rel_ex_valid", 64'(ex_if.valid), 64'd0);

        // back-to-back stream with EX always ready
        for (int unsigned i = 1; i <= 8; i++) begin
            push(8'(i), {32'(i), ~32'(i)}, 5'(i), 1'b1);
            @(negedge clk);
            chk("stream_op",       64'(ex_if.op),    64'(i));
            chk("stream_src",      ex_if.src,        {32'(i), ~32'(i)});
            chk("stream_ex_valid", 64'(ex_if.valid), 64'd1);
            chk("stream_id_ready", 64'(id_if.ready), 64'd1);
        end
        id_if.valid = 1'b0;
        @(negedge clk);
        chk("stream_drain", 64'(ex_if.valid), 64'd0);

        // stall: A then B fill MAIN and SKID
        ex_if.ready = 1'b0;
        push(8'hA1, 64'hAAAA, 5'd3, 1'b1);
        @(negedge clk);
        chk("stall_a_valid",    64'(ex_if.valid), 64'd1);
        chk("stall_a_id_ready", 64'(id_if.ready), 64'd1);
        push(8'hB2, 64'hBBBB, 5'd7, 1'b0);
        @(negedge clk);
        chk("full_id_ready", 64'(id_if.ready), 64'd0);
        chk("full_waddr",    64'(ex_if.waddr), 64'd3);
        chk("full_op",       64'(ex_if.op),    64'hA1);
        // offered data while FULL must be ignored
        push(8'hCC, 64'hCCCC, 5'd9, 1'b1);
        @(negedge clk);
        chk("full_hold_op", 64'(ex_if.op), 64'hA1);
        id_if.valid = 1'b0;
        ex_if.ready = 1'b1;
        @(negedge clk);
        chk("skid_b_op",    64'(ex_if.op),    64'hB2);
        chk("skid_b_waddr", 64'(ex_if.waddr), 64'd7);
        chk("skid_b_wen",   64'(ex_if.wen),   64'd0);
        @(negedge clk);
        chk("skid_empty", 64'(ex_if.valid), 64'd0);

        // flush while FULL with a competing input
        ex_if.ready = 1'b0;
        push(8'h11, 64'h1111, 5'd1, 1'b1);
        @(negedge clk);
        push(8'h22, 64'h2222, 5'd2, 1'b1);
        @(negedge clk);
        chk("pre_flush_full", 64'(id_if.ready), 64'd0);
        flush = 1'b1;
        push(8'h55, 64'h5555, 5'd5, 1'b1);
        @(negedge clk);
        chk("flush_ex_valid", 64'(ex_if.valid), 64'd0);
        chk("flush_ex_wen",   64'(ex_if.wen),   64'd0);
        chk("flush_id_ready", 64'(id_if.ready), 64'd1);
        chk("flush_op",       64'(ex_if.op),    64'd0);
        flush = 1'b0;
        id_if.valid = 1'b0;
        @(negedge clk);
        chk("flush_stay_empty", 64'(ex_if.valid), 64'd0);
        chk("flush_no_55",      64'(ex_if.op),    64'd0);

        // flush while BUSY with id_ready=1: input still dropped
        push(8'h66, 64'h6666, 5'd6, 1'b1);
        @(negedge clk);
        chk("busy_valid", 64'(ex_if.valid), 64'd1);
        flush = 1'b1;
        push(8'h77, 64'h7777, 5'd8, 1'b1);
        @(negedge clk);
        chk("busy_flush_valid", 64'(ex_if.valid), 64'd0);
        chk("busy_flush_src",   ex_if.src,        64'd0);
        flush = 1'b0;
        id_if.valid = 1'b0;
        @(negedge clk);
        chk("busy_flush_stay", 64'(ex_if.valid), 64'd0);

        // gated write enable with held payload
        push(8'h33, 64'h12345678_DEADBEEF, 5'd9, 1'b1);
        @(negedge clk);
        chk("wen_held", 64'(ex_if.wen), 64'd1);
        id_if.valid = 1'b0;
        ex_if.ready = 1'b1;
        @(negedge clk);
        chk("wen_gated",       64'(ex_if.wen),   64'd0);
        chk("wen_valid_low",   64'(ex_if.valid), 64'd0);
        chk("src_hold",        ex_if.src,        64'h12345678_DEADBEEF);
        @(negedge clk);
        chk("src_hold_lo",     64'(ex_if.src[31:0]), 64'hDEADBEEF);
        chk("waddr_hold",      64'(ex_if.waddr), 64'd9);
        chk("wen_gated_idle",  64'(ex_if.wen),   64'd0);

        // asynchronous reset while FULL
        ex_if.ready = 1'b0;
        push(8'h44, 64'h4444, 5'd4, 1'b1);
        @(negedge clk);
        push(8'h45, 64'h4545, 5'd5, 1'b1);
        @(negedge clk);
        chk("areset_pre_full", 64'(id_if.ready), 64'd0);
        id_if.valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("areset_ex_valid", 64'(ex_if.valid), 64'd0);
        chk("areset_ex_wen",   64'(ex_if.wen),   64'd0);
        chk("areset_id_ready", 64'(id_if.ready), 64'd1);
        chk("areset_ex_op",    64'(ex_if.op),    64'd0);
        @(negedge clk);
        rst = 1'b1;
        ex_if.ready = 1'b1;
        @(negedge clk);
        chk("areset_no_stale", 64'(ex_if.valid), 64'd0);
        @(negedge clk);
        chk("areset_no_stale2", 64'(ex_if.valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
